alu_share_arbiter: RTL and testbench

Shares one combinational 32-bit ALU between two requesters (e.g. branch/address unit and execute stage) using round-robin arbitration. Each accepted request is registered, applied to the ALU for one cycle, and its result and zero flag are returned on a shared response channel with valid/ready backpressure. The block sits between the requesters and the ALU instance and drives the ALU's op1/op2/alu_op inputs.

---
 rtl/alu_share_arbiter.sv | 77 +++++++
 tb/tb_alu_share_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_op1,
  input  logic [DATA_W-1:0] req0_op2,
  input  logic [OP_W-1:0]   req0_aluop,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_op1,
  input  logic [DATA_W-1:0] req1_op2,
  input  logic [OP_W-1:0]   req1_aluop,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state;
  logic last_grant;
  logic grant0, grant1;
  // On contention the requester that did not win last time gets the ALU
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end
  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      alu_op1 <= '0;
      alu_op2 <= '0;
      alu_sel <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_zero <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: if (grant0 | grant1) begin
          alu_op1 <= grant1 ? req1_op1 : req0_op1;
          alu_op2 <= grant1 ? req1_op2 : req0_op2;
          alu_sel <= grant1 ? req1_aluop : req0_aluop;
          rsp_id <= grant1;
          last_grant <= grant1;
          state <= EXEC;
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero <= alu_zero;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table-driven check of the shared-ALU arbiter with a behavioural ALU attached
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0] req0_aluop, req1_aluop;
  logic [31:0] alu_op1, alu_op2, alu_result, rsp_result;
  logic [3:0] alu_sel;
  logic alu_zero, rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  int n_checks = 0;
  int n_fails = 0;

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_aluop(req0_aluop),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_aluop(req1_aluop),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .busy(busy)
  );

  // The ALU the arbiter is meant to drive
  always_comb begin
    case (alu_sel)
      4'b0000: alu_result = alu_op1 & alu_op2;
      4'b0001: alu_result = alu_op1 | alu_op2;
      4'b0010: alu_result = alu_op1 + alu_op2;
      4'b0110: alu_result = alu_op1 - alu_op2;
      4'b0100: alu_result = {31'b0, $signed(alu_op1) < $signed(alu_op2)};
      4'b1000: alu_result = alu_op1 >> alu_op2[4:0];
      4'b1001: alu_result = alu_op1 << alu_op2[4:0];
      4'b1010: alu_result = $signed(alu_op1) >>> alu_op2[4:0];
      4'b0101: alu_result = alu_op1 ^ alu_op2;
      default: alu_result = 32'h0;
    endcase
    alu_zero = alu_result == 32'h0;
  end

  typedef struct {
    logic id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0] op;
    logic [31:0] res;
    logic z;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_op1 = a; req1_op2 = b; req1_aluop = op;
    end else begin
      req0_valid = 1'b1; req0_op1 = a; req0_op2 = b; req0_aluop = op;
    end
    #1;
  endtask

  task automatic wait_ready(input logic id);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (id ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("ready_wait", {31'b0, ok}, 32'd1);
  endtask

  task automatic run_op(input vec_t v);
    rsp_ready = 1'b1;
    drive(v.id, v.a, v.b, v.op);
    wait_ready(v.id);
    chk("other_ready_low", {31'b0, v.id ? req0_ready : req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("exec_busy", {31'b0, busy}, 32'd1);
    chk("exec_no_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("exec_op1", alu_op1, v.a);
    chk("exec_op2", alu_op2, v.b);
    chk("exec_sel", {28'b0, alu_sel}, {28'b0, v.op});
    tick();
    chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("rsp_id", {31'b0, rsp_id}, {31'b0, v.id});
    chk("rsp_result", rsp_result, v.res);
    chk("rsp_zero", {31'b0, rsp_zero}, {31'b0, v.z});
    tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0};
    vecs[1] = '{1'b0, 32'd3, 32'd3, 4'b0110, 32'd0, 1'b1};
    vecs[2] = '{1'b1, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 1'b0};
    vecs[3] = '{1'b0, 32'hF0F0, 32'h0FF0, 4'b0000, 32'h00F0, 1'b0};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'd4, 4'b1000, 32'h0800_0000, 1'b0};
    vecs[5] = '{1'b0, 32'd1, 32'd31, 4'b1001, 32'h8000_0000, 1'b0};
    vecs[6] = '{1'b1, 32'h8000_0000, 32'd4, 4'b1010, 32'hF800_0000, 1'b0};
    vecs[7] = '{1'b0, 32'hAAAA, 32'h5555, 4'b0101, 32'hFFFF, 1'b0};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0100, 32'd1, 1'b0};
    vecs[9] = '{1'b1, 32'h1234, 32'h5678, 4'b1111, 32'd0, 1'b1};
    req0_op1 = 0; req0_op2 = 0; req0_aluop = 0;
    req1_op1 = 0; req1_op2 = 0; req1_aluop = 0;
    rsp_ready = 1'b0;
    do_reset();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_id", {31'b0, rsp_id}, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_alu_op1", alu_op1, 32'd0);
    chk("reset_alu_sel", {28'b0, alu_sel}, 32'd0);
    chk("reset_ready0", {31'b0, req0_ready}, 32'd0);

    for (int i = 0; i < 10; i++) run_op(vecs[i]);

    // Continuous contention from reset: requester 0 first, then strict alternation
    do_reset();
    rsp_ready = 1'b1;
    drive(1'b0, 32'd3, 32'd3, 4'b0110);
    drive(1'b1, 32'hF0, 32'h0F, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      logic exp_id;
      exp_id = k[0];
      wait_ready(exp_id);
      chk("cont_grant0", {31'b0, req0_ready}, {31'b0, ~exp_id});
      chk("cont_grant1", {31'b0, req1_ready}, {31'b0, exp_id});
      tick();
      chk("cont_exec_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
      tick();
      chk("cont_resp_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
      chk("cont_rsp_id", {31'b0, rsp_id}, {31'b0, exp_id});
      chk("cont_rsp_result", rsp_result, exp_id ? 32'hFF : 32'd0);
      chk("cont_rsp_zero", {31'b0, rsp_zero}, {31'b0, ~exp_id});
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Backpressure on a signed compare from requester 1, requester 0 kept waiting
    do_reset();
    rsp_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0100);
    wait_ready(1'b1);
    tick();
    req1_valid = 1'b0;
    drive(1'b0, 32'd9, 32'd9, 4'b0010);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_id", {31'b0, rsp_id}, 32'd1);
      chk("bp_rsp_result", rsp_result, 32'd1);
      chk("bp_rsp_zero", {31'b0, rsp_zero}, 32'd0);
      chk("bp_no_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle", {31'b0, busy}, 32'd0);
    chk("bp_rsp_cleared", {31'b0, rsp_valid}, 32'd0);
    chk("bp_req0_now_ready", {31'b0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    #1;

    // Reset during EXEC drops the pending operation
    drive(1'b0, 32'h8000_0000, 32'd4, 4'b1010);
    wait_ready(1'b0);
    tick();
    req0_valid = 1'b0;
    chk("rst_in_exec_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_exec_idle", {31'b0, busy}, 32'd0);
    chk("rst_exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("rst_exec_no_late_rsp", {31'b0, rsp_valid}, 32'd0);
    run_op('{1'b0, 32'hAAAA, 32'hAAAA, 4'b0101, 32'd0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
